rx_shift_engine: RTL

Receive datapath for the full UART, downstream of RX_Controller.
- Shifts serial RX into a 10-bit shift register on each controller BTU pulse.
- On the controller's DONE pulse, right-justifies the frame for the configured EIGHT/PEN format, checks parity and stop bit, and latches the data byte.
- Presents the byte and sticky status flags (RXRDY, PERR, FERR, OVF) to the SoC-side read interface.

---
 rtl/rx_shift_engine_pkg.sv | 16 +
 rtl/rx_frame_remap.sv | 40 ++++
 rtl/rx_shift_engine.sv | 86 ++++++++
 3 files changed

// File: rtl/rx_shift_engine_pkg.sv
// Shared UART receive-side constants: shift register geometry, parity sense
// encodings and data-width choices.
package rx_shift_engine_pkg;

    localparam int unsigned    SR_W    = 10;
    localparam logic [SR_W-1:0] SR_IDLE = 10'h3FF;

    localparam int unsigned D7 = 7;
    localparam int unsigned D8 = 8;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_sense_e;

endpackage

// File: rtl/rx_frame_remap.sv
// Combinational frame decode: right-justifies the received frame for the
// EIGHT/PEN format and checks the parity and stop bits.
module rx_frame_remap
    import rx_shift_engine_pkg::*;
(
    input  logic [SR_W-1:0] sr_next,
    input  logic            EIGHT,
    input  logic            PEN,
    input  logic            OHEL,
    output logic [D8-1:0]   data,
    output logic            par_bad,
    output logic            stop_bad
);

    logic par_bit;
    logic exp_par;

    // Frame is LSB-first and ends at bit 9, so shorter formats start higher up.
    always_comb begin
        data    = '0;
        par_bit = 1'b0;
        unique case ({EIGHT, PEN})
            2'b11: begin
                data    = sr_next[D7:0];
                par_bit = sr_next[D8];
            end
            2'b10: data = sr_next[D8:1];
            2'b01: begin
                data    = {1'b0, sr_next[D7:1]};
                par_bit = sr_next[D8];
            end
            default: data = {1'b0, sr_next[D8:2]};
        endcase
    end

    assign exp_par  = (^data) ^ (OHEL == PAR_ODD);
    assign par_bad  = PEN & (par_bit != exp_par);
    assign stop_bad = ~sr_next[SR_W-1];

endmodule

// File: rtl/rx_shift_engine.sv
// UART receive datapath: serial shift register, byte latch, sticky status
// flags and the SoC-side read/clear handshake.
module rx_shift_engine
    import rx_shift_engine_pkg::*;
#(
    parameter bit FLAG_CLR_ON_READ = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       BTU,
    input  logic       START,
    input  logic       DONE,
    input  logic       EIGHT,
    input  logic       PEN,
    input  logic       OHEL,
    input  logic       READ,
    input  logic       CLR,
    output logic [7:0] DATA,
    output logic       RXRDY,
    output logic       PERR,
    output logic       FERR,
    output logic       OVF
);

    logic [SR_W-1:0] sr;
    logic [SR_W-1:0] sr_next;
    logic            shift;
    logic [D8-1:0]   data;
    logic            par_bad;
    logic            stop_bad;
    logic            flag_clr;
    logic            perr_set;
    logic            ferr_set;
    logic            ovf_set;

    assign shift   = BTU & ~START;
    assign sr_next = shift ? {RX, sr[SR_W-1:1]} : sr;

    rx_frame_remap u_remap (
        .sr_next  (sr_next),
        .EIGHT    (EIGHT),
        .PEN      (PEN),
        .OHEL     (OHEL),
        .data     (data),
        .par_bad  (par_bad),
        .stop_bad (stop_bad)
    );

    // A read of an empty register is ignored, including its flag-clear side effect.
    assign flag_clr = CLR | (FLAG_CLR_ON_READ & READ & RXRDY);
    assign perr_set = DONE & par_bad;
    assign ferr_set = DONE & stop_bad;
    assign ovf_set  = DONE & RXRDY & ~READ;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= SR_IDLE;
        end else if (DONE && !shift) begin
            sr <= SR_IDLE;
        end else begin
            sr <= sr_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            DATA  <= '0;
            RXRDY <= 1'b0;
            PERR  <= 1'b0;
            FERR  <= 1'b0;
            OVF   <= 1'b0;
        end else begin
            if (DONE) begin
                DATA  <= data;
                RXRDY <= 1'b1;
            end else if (READ) begin
                RXRDY <= 1'b0;
            end
            PERR <= perr_set | (PERR & ~flag_clr);
            FERR <= ferr_set | (FERR & ~flag_clr);
            OVF  <= ovf_set  | (OVF  & ~flag_clr);
        end
    end

endmodule
